// File: rtl/click_sync_bridge_pkg.sv
// Shared constants and helpers for the click-to-synchronous bridge.
package click_sync_bridge_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int SYNC_STAGES_MIN = 2;

    // Number of bits needed to index 'value' entries (ceil(log2(value))).
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/click_sync_bridge_toggle_sync.sv
// Multi-flop synchroniser for the 2-phase request level coming from the
// asynchronous click chain. The input feeds the first flop directly so no
// combinational glitch can be captured.
module click_sync_bridge_toggle_sync
    import click_sync_bridge_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [STAGES-1:0] sync_r;

    // Shift the raw request level through the synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/click_sync_bridge.sv
// Bridge from a 2-phase bundled-data click chain into the clk domain.
// The request level is synchronised, compared against the last accepted
// phase, and each new phase pushes one word into a small FIFO. The ack is
// the registered accepted phase, so it is simply withheld while full.
module click_sync_bridge
    import click_sync_bridge_pkg::*;
#(
    parameter  int DATA_W      = DEFAULT_DATA_W,
    parameter  int DEPTH       = 4,
    parameter  int SYNC_STAGES = SYNC_STAGES_MIN,
    localparam int PTR_W       = clog2_f(DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inR,
    input  logic [DATA_W-1:0] inData,
    output logic              outA,
    output logic              outValid,
    output logic [DATA_W-1:0] outData,
    input  logic              outReady,
    output logic [CNT_W-1:0]  fifoCount
);

    logic              req_sync_s;
    logic              req_seen_r;
    logic              new_req_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    click_sync_bridge_toggle_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (inR),
        .q   (req_sync_s)
    );

    assign outA      = req_seen_r;
    assign fifoCount = count_r;
    assign outValid  = (count_r != {CNT_W{1'b0}});
    assign outData   = mem_r[rd_ptr_r];

    // Decide push/pop; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        new_req_s = (req_sync_s != req_seen_r);
        full_s    = (count_r == CNT_W'(DEPTH));
        pop_s     = outValid & outReady;
        if (new_req_s && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Handshake phase, FIFO pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_seen_r <= 1'b0;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                req_seen_r <= ~req_seen_r;
                wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= inData;
        end
    end

endmodule

// File: tb/tb_click_sync_bridge.sv
// Directed bench for click_sync_bridge with a queue-based reference model
// checked against the DUT every cycle, plus literal spot checks.
module tb_click_sync_bridge;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic          clk;
    logic          rst;
    logic          inR;
    logic [DW-1:0] inData;
    logic          outA;
    logic          outValid;
    logic [DW-1:0] outData;
    logic          outReady;
    logic [2:0]    fifoCount;

    int total = 0;
    int bad   = 0;
    int max_cnt = 0;

    click_sync_bridge #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inR       (inR),
        .inData    (inData),
        .outA      (outA),
        .outValid  (outValid),
        .outData   (outData),
        .outReady  (outReady),
        .fifoCount (fifoCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: request seen in clk domain SS edges after it is driven,
    // words kept in a plain queue, ack is the parity of accepted words.
    logic [DW-1:0] mq[$];
    bit            m_ack;
    bit            m_dly[SS];
    bit            m_pend, m_pop, m_push;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ack = 1'b0;
            for (int i = 0; i < SS; i++) m_dly[i] = 1'b0;
        end else begin
            m_pend = (m_dly[SS-1] != m_ack);
            m_pop  = (mq.size() != 0) && outReady;
            m_push = m_pend && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(inData);
                m_ack = ~m_ack;
            end
            for (int i = SS - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
            m_dly[0] = inR;
        end
    end

    // Words actually handed out by the DUT.
    logic [DW-1:0] dut_log[$];
    always @(posedge clk) begin
        if (rst && outValid && outReady) dut_log.push_back(outData);
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("outA_model", {31'd0, outA}, {31'd0, m_ack});
            chk("outValid_model", {31'd0, outValid}, {31'd0, (mq.size() != 0)});
            chk("fifoCount_model", {29'd0, fifoCount}, mq.size());
            if (mq.size() != 0) chk("outData_model", outData, mq[0]);
            if (int'(fifoCount) > max_cnt) max_cnt = int'(fifoCount);
        end
    end

    task automatic wait_ack();
        for (int i = 0; i < 40 && outA != inR; i++) @(negedge clk);
        chk("ack_wait", {31'd0, outA}, {31'd0, inR});
    endtask

    task automatic send(input logic [DW-1:0] w);
        wait_ack();
        @(negedge clk);
        inData = w;
        inR    = ~inR;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        inR = 1'b0;
        outReady = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dut_log.delete();
        max_cnt = 0;
    endtask

    task automatic chk_log(input string name, input int n, input int first);
        chk({name, "_len"}, dut_log.size(), n);
        for (int i = 0; i < n && i < dut_log.size(); i++)
            chk(name, dut_log[i], first + i);
    endtask

    initial begin
        rst = 1'b0; inR = 1'b0; inData = '0; outReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outA", {31'd0, outA}, 32'd0);
        chk("rst_outValid", {31'd0, outValid}, 32'd0);
        chk("rst_count", {29'd0, fifoCount}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single word latency
        @(negedge clk);
        inData = 32'hDEADBEEF;
        inR = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("single_outA_e2", {31'd0, outA}, 32'd0);
        @(posedge clk); #1;
        chk("single_outA_e3", {31'd0, outA}, 32'd1);
        chk("single_valid_e3", {31'd0, outValid}, 32'd1);
        chk("single_data", outData, 32'hDEADBEEF);
        chk("single_count", {29'd0, fifoCount}, 32'd1);

        // Fill and stall
        do_reset();
        for (int k = 1; k <= 5; k++) send(k);
        repeat (10) @(negedge clk);
        chk("full_count", {29'd0, fifoCount}, 32'd4);
        chk("full_outA", {31'd0, outA}, 32'd0);
        chk("full_head", outData, 32'd1);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        chk("fullpop_count", {29'd0, fifoCount}, 32'd4);
        chk("fullpop_outA", {31'd0, outA}, 32'd1);
        chk("fullpop_head", outData, 32'd2);
        chk_log("fullpop_word", 1, 1);
        outReady = 1'b1;
        repeat (6) @(negedge clk);
        outReady = 1'b0;
        chk_log("fill_order", 5, 1);

        // Simultaneous push and pop at count 2
        do_reset();
        send(1);
        send(2);
        wait_ack();
        chk("pp_count_before", {29'd0, fifoCount}, 32'd2);
        @(negedge clk);
        inData = 3;
        inR = ~inR;
        @(negedge clk);
        @(negedge clk);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        chk("pp_count_after", {29'd0, fifoCount}, 32'd2);
        chk("pp_outA", {31'd0, outA}, 32'd1);
        outReady = 1'b1;
        repeat (4) @(negedge clk);
        chk_log("pp_order", 3, 1);

        // Streaming across pointer wrap
        do_reset();
        outReady = 1'b1;
        for (int k = 1; k <= 10; k++) send(k);
        wait_ack();
        repeat (4) @(negedge clk);
        chk_log("wrap_order", 10, 1);
        chk("wrap_max_count_le2", {31'd0, (max_cnt <= 2)}, 32'd1);

        // Empty pops must not move the read pointer
        repeat (8) @(negedge clk);
        chk("empty_count", {29'd0, fifoCount}, 32'd0);
        chk("empty_valid", {31'd0, outValid}, 32'd0);
        outReady = 1'b0;
        send(32'hCAFE0006);
        wait_ack();
        @(negedge clk);
        chk("empty_then_data", outData, 32'hCAFE0006);
        chk("empty_then_count", {29'd0, fifoCount}, 32'd1);

        // Reset in the middle of traffic
        send(7);
        send(8);
        @(negedge clk);
        #2;
        rst = 1'b0;
        inR = 1'b0;
        #1;
        chk("midrst_outA", {31'd0, outA}, 32'd0);
        chk("midrst_valid", {31'd0, outValid}, 32'd0);
        chk("midrst_count", {29'd0, fifoCount}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("postrst_count", {29'd0, fifoCount}, 32'd0);
        chk("postrst_outA", {31'd0, outA}, 32'd0);
        chk("postrst_valid", {31'd0, outValid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
